// File: rtl/axo32_ifetch_pkg.sv
// ============================================================================
// Module   : axo32_ifetch_pkg
// Purpose  : Shared types and constants for the axo32 instruction fetch unit.
//            Defines the NOP word, the FSM state encodings, the FIFO entry
//            layout and a word-alignment helper.
// Ports    : none (package)
// Config   : AXO_IFETCH_BUSERR_EN adds a fault bit to every FIFO entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axo32_ifetch_pkg;

    // Instruction substituted for the data of a faulted fetch (addi x0,x0,0).
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Fetch FSM state encodings.
    localparam logic [0:0] S_FETCH   = 1'b0;
    localparam logic [0:0] S_DISCARD = 1'b1;

    // One buffered fetch result.
    typedef struct packed {
`ifdef AXO_IFETCH_BUSERR_EN
        logic        fault;
`endif
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Clears the byte-offset bits; written as a mask so every input bit is used.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axo32_ifetch_if.sv
// ============================================================================
// Module   : axo32_ifetch_if
// Purpose  : Bundles the instruction-memory bus and the decoder handshake of
//            the fetch unit.
// Signals  : mem_req/mem_addr (fetch -> memory), mem_ack/mem_rdata (memory ->
//            fetch), inst_valid/inst/inst_pc (fetch -> decoder), inst_ready
//            (decoder -> fetch). With AXO_IFETCH_BUSERR_EN also mem_err
//            (memory -> fetch) and inst_fault (fetch -> decoder).
// Modports : master = fetch unit, slave = memory + decoder side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axo32_ifetch_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef AXO_IFETCH_BUSERR_EN
    logic        mem_err;
    logic        inst_fault;
`endif

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
`ifdef AXO_IFETCH_BUSERR_EN
        input  mem_err,
        output inst_fault,
`endif
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
`ifdef AXO_IFETCH_BUSERR_EN
        output mem_err,
        input  inst_fault,
`endif
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );

endinterface

`default_nettype wire

// File: rtl/axo32_ifetch_fifo.sv
// ============================================================================
// Module   : axo32_ifetch_fifo
// Purpose  : Synchronous FIFO with push, pop, flush and occupancy count.
//            Head word is presented combinationally on rdata.
// Ports    : clk, rst (async, active-low), push, pop, flush, wdata,
//            rdata (head), count (occupancy).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axo32_ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic                       flush,
    input  wire logic [WIDTH-1:0]           wdata,
    output logic      [WIDTH-1:0]           rdata,
    output logic      [$clog2(DEPTH+1)-1:0] count
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A pop frees the head slot in the same cycle, so a push into a full
    // FIFO is accepted whenever it coincides with a pop.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != FULL) || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

`default_nettype wire

// File: rtl/axo32_ifetch.sv
// ============================================================================
// Module   : axo32_ifetch
// Purpose  : Instruction fetch unit. Issues single-outstanding word reads to
//            instruction memory, buffers {inst, pc} pairs in a small FIFO and
//            hands them to the decoder over a valid/ready handshake. A
//            redirect flushes the buffer and restarts fetch at a new PC.
// Ports    : clk            rising-edge clock
//            rst            asynchronous active-low reset
//            redirect       flush and restart at redirect_pc
//            redirect_pc    new PC, bits [1:0] ignored
//            bus            axo32_ifetch_if.master (memory bus + decoder side)
// Params   : RESET_VEC (first fetch PC), FIFO_DEPTH (2..8)
// Config   : AXO_IFETCH_BUSERR_EN enables mem_err/inst_fault: an errored ack
//            pushes a NOP marked as faulted and halts fetch until redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axo32_ifetch
    import axo32_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        redirect,
    input  wire logic [31:0] redirect_pc,
    axo32_ifetch_if.master   bus
);

    localparam int          CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] START_PC = RESET_VEC & 32'hFFFF_FFFC;

    logic [0:0]    state;
    logic          req;
    logic [31:0]   addr;
    logic [31:0]   fetch_pc;
    logic [31:0]   target;
    logic [CW-1:0] count;
    logic          valid;
    logic          ack;
    logic          push;
    logic          pop;
    logic          can_issue;
    logic          halted;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // req doubles as the "one request outstanding" flag.
    assign ack       = req && bus.mem_ack;
    assign valid     = (count != '0);
    assign pop       = valid && bus.inst_ready;
    assign push      = ack && (state == S_FETCH) && !redirect;
    assign target    = word_align(redirect_pc);
    assign can_issue = !req && (state == S_FETCH) && !halted
                       && (count < CW'(FIFO_DEPTH));

    assign push_entry.pc = addr;
`ifdef AXO_IFETCH_BUSERR_EN
    assign push_entry.fault = bus.mem_err;
    assign push_entry.inst  = bus.mem_err ? INST_NOP : bus.mem_rdata;

    // Once a faulted word is buffered nothing more is fetched down that path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (redirect) begin
            halted <= 1'b0;
        end else if (push && bus.mem_err) begin
            halted <= 1'b1;
        end
    end

    assign bus.inst_fault = valid && head.fault;
`else
    assign push_entry.inst = bus.mem_rdata;
    assign halted          = 1'b0;
`endif

    // Request/FSM control. A redirect that finds the bus idle, or whose
    // request is acked in the same cycle, issues the new address right away;
    // a redirect that hits an un-acked request must keep the bus stable, so
    // it parks in DISCARD and issues once that stale ack arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            req      <= 1'b0;
            addr     <= START_PC;
            fetch_pc <= START_PC;
        end else if (redirect) begin
            if (req && !bus.mem_ack) begin
                state    <= S_DISCARD;
                fetch_pc <= target;
            end else begin
                state    <= S_FETCH;
                req      <= 1'b1;
                addr     <= target;
                fetch_pc <= target + 32'd4;
            end
        end else if (state == S_DISCARD) begin
            if (ack) begin
                state    <= S_FETCH;
                req      <= 1'b1;
                addr     <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
        end else if (ack) begin
            // Dropping req for a cycle keeps mem_req purely registered.
            req <= 1'b0;
        end else if (can_issue) begin
            req      <= 1'b1;
            addr     <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    axo32_ifetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_entry),
        .rdata (head),
        .count (count)
    );

    assign bus.mem_req    = req;
    assign bus.mem_addr   = addr;
    assign bus.inst_valid = valid;
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;

endmodule

`default_nettype wire

// File: tb/tb_axo32_ifetch.sv
// ============================================================================
// Module   : tb_axo32_ifetch
// Purpose  : Self-checking bench for axo32_ifetch (RESET_VEC=0x100, depth 2).
//            Memory model returns addr ^ XOR_KEY after a programmable number
//            of wait cycles (0 = same-cycle ack).
// Config   : AXO_IFETCH_BUSERR_EN adds the bus-error sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axo32_ifetch;
    import axo32_ifetch_pkg::*;

    localparam logic [31:0] RV      = 32'h0000_0100;
    localparam logic [31:0] XOR_KEY = 32'hA5A5_5A5A;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    int          lat;
    int          wait_cnt;
    int          n_checks;
    int          n_errors;
    vec_t        tbl[15];

    axo32_ifetch_if bus();

    axo32_ifetch #(
        .RESET_VEC  (RV),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_ack   = bus.mem_req && (wait_cnt >= lat);
    assign bus.mem_rdata = bus.mem_addr ^ XOR_KEY;

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
    end

`ifdef AXO_IFETCH_BUSERR_EN
    int ack_num;
    always @(posedge clk or negedge rst) begin
        if (!rst)                              ack_num <= 0;
        else if (bus.mem_req && bus.mem_ack)   ack_num <= ack_num + 1;
    end
    assign bus.mem_err = (ack_num == 1);
`endif

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic ready);
        rst            = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        bus.inst_ready = ready;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Consumes n entries (inst_ready must be high), expecting consecutive PCs.
    task automatic expect_pops(input int n, input logic [31:0] first_pc, input string tag);
        int          got    = 0;
        int          budget = 0;
        logic [31:0] pc     = first_pc;
        while (got < n && budget < 60) begin
            if (bus.inst_valid && bus.inst_ready) begin
                chk({tag, "_pc"},   bus.inst_pc, pc);
                chk({tag, "_inst"}, bus.inst,    pc ^ XOR_KEY);
                pc += 32'd4;
                got++;
            end
            tick();
            budget++;
        end
        if (got < n) chk({tag, "_timeout"}, got, n);
    endtask

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic req,
                                input logic [31:0] addr, input logic vld, input logic [31:0] pc);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
        return v;
    endfunction

    initial begin
        int nreq;
        n_checks = 0;
        n_errors = 0;
        lat      = 0;

        // Streaming from reset, then redirect near the top of the address space.
        tbl[0]  = mk(0, 0, 0, 32'h0,         0, 32'h0);
        tbl[1]  = mk(0, 0, 1, 32'h100,       0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 32'h0,         1, 32'h100);
        tbl[3]  = mk(0, 0, 1, 32'h104,       0, 32'h0);
        tbl[4]  = mk(0, 0, 0, 32'h0,         1, 32'h104);
        tbl[5]  = mk(0, 0, 1, 32'h108,       0, 32'h0);
        tbl[6]  = mk(0, 0, 0, 32'h0,         1, 32'h108);
        tbl[7]  = mk(0, 0, 1, 32'h10C,       0, 32'h0);
        tbl[8]  = mk(1, 32'hFFFF_FFFA, 0, 32'h0, 1, 32'h10C);
        tbl[9]  = mk(0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0);
        tbl[10] = mk(0, 0, 0, 32'h0,         1, 32'hFFFF_FFF8);
        tbl[11] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        tbl[12] = mk(0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC);
        tbl[13] = mk(0, 0, 1, 32'h0,         0, 32'h0);
        tbl[14] = mk(0, 0, 0, 32'h0,         1, 32'h0);

        @(negedge clk);
        rst            = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        bus.inst_ready = 1'b1;
        tick();
        chk("rst_req",   bus.mem_req,    0);
        chk("rst_addr",  bus.mem_addr,   RV);
        chk("rst_valid", bus.inst_valid, 0);
        chk("rst_inst",  bus.inst,       0);
        chk("rst_pc",    bus.inst_pc,    0);
`ifdef AXO_IFETCH_BUSERR_EN
        chk("rst_fault", bus.inst_fault, 0);
`endif
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            chk($sformatf("t1_req[%0d]", i),   bus.mem_req,    tbl[i].req);
            if (tbl[i].req) chk($sformatf("t1_addr[%0d]", i), bus.mem_addr, tbl[i].addr);
            chk($sformatf("t1_valid[%0d]", i), bus.inst_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                chk($sformatf("t1_pc[%0d]", i),   bus.inst_pc, tbl[i].pc);
                chk($sformatf("t1_inst[%0d]", i), bus.inst,    tbl[i].pc ^ XOR_KEY);
            end
            redirect    = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            tick();
        end
        redirect = 1'b0;

        // Stalled consumer: exactly FIFO_DEPTH requests, head held stable.
        do_reset(1'b0);
        nreq = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus.mem_req && bus.mem_ack) nreq++;
            if (k >= 2) begin
                chk("t2_hold_pc",   bus.inst_pc, 32'h100);
                chk("t2_hold_inst", bus.inst,    32'h100 ^ XOR_KEY);
            end
        end
        chk("t2_req_count", nreq, 2);
        chk("t2_req_low",   bus.mem_req, 0);
        bus.inst_ready = 1'b1;
        expect_pops(3, 32'h100, "t2_resume");

        // Redirect while a 3-wait request is outstanding.
        do_reset(1'b1);
        lat = 3;
        tick();
        tick();
        chk("t3_pending", {bus.mem_req, bus.mem_ack}, 2'b10);
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        chk("t3_hold_req",  bus.mem_req,    1);
        chk("t3_hold_addr", bus.mem_addr,   32'h100);
        chk("t3_flush",     bus.inst_valid, 0);
        nreq = 0;
        for (int k = 0; k < 20 && !(bus.mem_req && bus.mem_addr != 32'h100); k++) begin
            if (bus.inst_valid) nreq++;
            tick();
        end
        chk("t3_no_stale", nreq, 0);
        chk("t3_new_addr", bus.mem_addr, 32'h200);
        expect_pops(2, 32'h200, "t3_after");

        // Reset in the middle of a wait.
        lat = 7;
        for (int k = 0; k < 20 && !bus.mem_req; k++) tick();
        tick();
        chk("t7_pre_req", bus.mem_req, 1);
        rst = 1'b0;
        #1;
        chk("t7_req",   bus.mem_req,    0);
        chk("t7_addr",  bus.mem_addr,   RV);
        chk("t7_valid", bus.inst_valid, 0);
        chk("t7_inst",  bus.inst,       0);
        chk("t7_pc",    bus.inst_pc,    0);
`ifdef AXO_IFETCH_BUSERR_EN
        chk("t7_fault", bus.inst_fault, 0);
`endif
        @(negedge clk);

        // Redirect coinciding with a same-cycle ack and a pop.
        lat = 0;
        do_reset(1'b0);
        tick();
        tick();
        tick();
        chk("t4_setup", {bus.mem_req, bus.mem_ack, bus.inst_valid}, 3'b111);
        bus.inst_ready = 1'b1;
        redirect       = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect = 1'b0;
        chk("t4_flush",    bus.inst_valid, 0);
        chk("t4_req",      bus.mem_req,    1);
        chk("t4_req_addr", bus.mem_addr,   32'h300);
        expect_pops(2, 32'h300, "t4_after");

`ifdef AXO_IFETCH_BUSERR_EN
        // Second ack errors: NOP with fault, then fetch halts until redirect.
        do_reset(1'b1);
        nreq = 0;
        for (int k = 0; k < 30 && nreq < 2; k++) begin
            if (bus.inst_valid) begin
                if (nreq == 0) begin
                    chk("t6_pc0",    bus.inst_pc,    32'h100);
                    chk("t6_fault0", bus.inst_fault, 0);
                end else begin
                    chk("t6_pc1",    bus.inst_pc,    32'h104);
                    chk("t6_fault1", bus.inst_fault, 1);
                    chk("t6_nop",    bus.inst,       INST_NOP);
                end
                nreq++;
            end
            tick();
        end
        chk("t6_entries", nreq, 2);
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.mem_req) nreq++;
            tick();
        end
        chk("t6_halted", nreq, 0);
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        chk("t6_restart_req",  bus.mem_req,  1);
        chk("t6_restart_addr", bus.mem_addr, 32'h400);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
